// File: rtl/pio_mem_pkg.sv
// Shared definitions for the PIO memory requester.
// Holds the FSM state encoding, the bus widths and the address region codes
// that sit in cmd_addr[13:12].
package pio_mem_pkg;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WR_BE_W = 8;

  // Region selects carried in the top two address bits
  localparam logic [1:0] REGION_BAR0 = 2'b01;
  localparam logic [1:0] REGION_ROM  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_e;

endpackage

// File: rtl/pio_mem_requester_if.sv
// Bus bundle for the PIO memory requester.
//   cmd_*  : command channel (valid/ready), one command at a time
//   rsp_*  : completion channel (valid/ready)
//   rd_*   : target read port (fixed-latency)
//   wr_*   : target write port, throttled by wr_busy
// master = the requester, slave = the command source / memory target side.
interface pio_mem_requester_if;
  import pio_mem_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [BE_W-1:0]     cmd_be;
  logic [DATA_W-1:0]   cmd_wdata;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_error;

  logic [ADDR_W-1:0]   rd_addr;
  logic [BE_W-1:0]     rd_be;
  logic [DATA_W-1:0]   rd_data;

  logic [ADDR_W-1:0]   wr_addr;
  logic [WR_BE_W-1:0]  wr_be;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic                wr_busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    input  rsp_ready,
    output rd_addr, rd_be,
    input  rd_data,
    output wr_addr, wr_be, wr_data, wr_en,
    input  wr_busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    output rsp_ready,
    input  rd_addr, rd_be,
    output rd_data,
    input  wr_addr, wr_be, wr_data, wr_en,
    output wr_busy
  );

endinterface

// File: rtl/pio_mem_requester.sv
// PIO memory requester: accepts one read/write command at a time, drives the
// target read or write port, and returns a single completion.
// Ports:
//   clk        rising-edge clock
//   sys_rst_n  asynchronous active-low reset
//   bus        pio_mem_requester_if.master (cmd / rsp / rd / wr channels)
// Parameters:
//   TCQ           clock-to-output delay for simulation models (kept for
//                 compatibility; this RTL uses zero-delay assignments)
//   RD_LATENCY    target read latency in cycles, 1..7
//   BUSY_TIMEOUT  consecutive wr_busy cycles before a write is abandoned, 1..255
module pio_mem_requester
  import pio_mem_pkg::*;
#(
  parameter int          TCQ          = 1,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 sys_rst_n,
  pio_mem_requester_if.master bus
);

  localparam int unsigned RD_CNT_W   = 3;
  localparam int unsigned BUSY_CNT_W = 8;

  // Elaboration-time parameter legality
  if (TCQ < 0) begin : g_bad_tcq
    $error("pio_mem_requester: TCQ must be non-negative");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_rd_latency
    $error("pio_mem_requester: RD_LATENCY must be 1..7");
  end
  if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > 255) begin : g_bad_busy_timeout
    $error("pio_mem_requester: BUSY_TIMEOUT must be 1..255");
  end

  state_e                state;
  logic [RD_CNT_W-1:0]   rd_cnt;
  logic [BUSY_CNT_W-1:0] busy_cnt;
  logic                  busy_expire_c;

  // This busy cycle is the BUSY_TIMEOUT-th consecutive one
  assign busy_expire_c = (busy_cnt == BUSY_CNT_W'(BUSY_TIMEOUT - 1));

  assign bus.cmd_ready = (state == ST_IDLE);
  // Write strobe follows wr_busy combinationally so the target sees it the
  // same cycle it frees up
  assign bus.wr_en     = (state == ST_WRITE) && !bus.wr_busy;

  // FSM, counters and registered target/response fields
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      rd_cnt        <= '0;
      busy_cnt      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
      bus.rd_addr   <= '0;
      bus.rd_be     <= '0;
      bus.wr_addr   <= '0;
      bus.wr_be     <= '0;
      bus.wr_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_write) begin
              bus.wr_addr <= bus.cmd_addr;
              bus.wr_be   <= {4'b0, bus.cmd_be};
              bus.wr_data <= bus.cmd_wdata;
              busy_cnt    <= '0;
              state       <= ST_WRITE;
            end else begin
              bus.rd_addr <= bus.cmd_addr;
              bus.rd_be   <= bus.cmd_be;
              rd_cnt      <= RD_CNT_W'(RD_LATENCY);
              state       <= ST_READ_WAIT;
            end
          end
        end

        ST_WRITE: begin
          if (!bus.wr_busy) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b0;
            bus.rsp_rdata <= '0;
            busy_cnt      <= '0;
            state         <= ST_RESP;
          end else if (busy_expire_c) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b1;
            bus.rsp_rdata <= '0;
            busy_cnt      <= '0;
            state         <= ST_RESP;
          end else begin
            busy_cnt <= busy_cnt + BUSY_CNT_W'(1);
          end
        end

        // rd_cnt reaches zero one edge before capture, giving E0+RD_LATENCY+1
        ST_READ_WAIT: begin
          if (rd_cnt == '0) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b0;
            bus.rsp_rdata <= bus.rd_data;
            state         <= ST_RESP;
          end else begin
            rd_cnt <= rd_cnt - RD_CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_mem_requester.sv
// Directed bench for pio_mem_requester: write, read, busy back-pressure,
// busy timeout, response stall and mid-read reset.
module tb_pio_mem_requester;
  import pio_mem_pkg::*;

  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned BUSY_TO = 8;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned wr_en_cnt = 0;

  pio_mem_requester_if bif ();

  pio_mem_requester #(
    .TCQ         (1),
    .RD_LATENCY  (RD_LAT),
    .BUSY_TIMEOUT(BUSY_TO)
  ) dut (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bif)
  );

  always #5 clk = ~clk;

  // Target memory contents
  function automatic logic [31:0] target_word(input logic [13:0] a);
    case (a)
      14'h1002: return 32'h00377600;
      14'h3005: return 32'hCAFEF00D;
      default:  return 32'hA5A50000 | 32'(a);
    endcase
  endfunction

  // One-cycle-latency target read port
  always @(posedge clk) bif.rd_data <= target_word(bif.rd_addr);

  always @(posedge clk) if (bif.wr_en === 1'b1) wr_en_cnt <= wr_en_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present a command at a negedge; returns one negedge after the accept edge E0
  task automatic issue(input logic wr, input logic [13:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = wr;
    bif.cmd_addr  = addr;
    bif.cmd_be    = be;
    bif.cmd_wdata = wd;
    check("cmd_ready_pre", 32'(bif.cmd_ready), 32'h1);
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    check("cmd_ready_busy", 32'(bif.cmd_ready), 32'h0);
  endtask

  // Cycles from E0 until rsp_valid is seen, bounded
  task automatic wait_rsp(input string tag, input int unsigned exp_lat);
    int unsigned cyc;
    cyc = 1;
    while (bif.rsp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      if (bif.rsp_valid !== 1'b1) cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
  endtask

  task automatic handshake(input string tag);
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, 32'(bif.rsp_valid), 32'h0);
    check({tag, "_idle"}, 32'(bif.cmd_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    sys_rst_n     = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_be    = '0;
    bif.cmd_wdata = '0;
    bif.rsp_ready = 1'b0;
    bif.wr_busy   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bif.cmd_ready), 32'h1);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 32'h0);
    check("rst_rsp_rdata", bif.rsp_rdata, 32'h0);
    check("rst_wr_en", 32'(bif.wr_en), 32'h0);
    check("rst_rd_addr", 32'(bif.rd_addr), 32'h0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // Plain write, no busy
    base = wr_en_cnt;
    issue(1'b1, {REGION_BAR0, 12'h000}, 4'hF, 32'h0A0015C8);
    check("w_wr_en", 32'(bif.wr_en), 32'h1);
    check("w_wr_be", 32'(bif.wr_be), 32'h0F);
    check("w_wr_addr", 32'(bif.wr_addr), 32'h1000);
    check("w_wr_data", bif.wr_data, 32'h0A0015C8);
    wait_rsp("w", 1);
    check("w_err", 32'(bif.rsp_error), 32'h0);
    check("w_rdata", bif.rsp_rdata, 32'h0);
    check("w_wr_en_after", 32'(bif.wr_en), 32'h0);
    handshake("w");
    check("w_pulses", 32'(wr_en_cnt - base), 32'h1);

    // Read, one-cycle target latency
    issue(1'b0, {REGION_BAR0, 12'h002}, 4'hC, 32'hFFFFFFFF);
    check("r_rd_addr", 32'(bif.rd_addr), 32'h1002);
    check("r_rd_be", 32'(bif.rd_be), 32'hC);
    check("r_wr_en", 32'(bif.wr_en), 32'h0);
    wait_rsp("r", 2);
    check("r_rd_addr_held", 32'(bif.rd_addr), 32'h1002);
    check("r_rdata", bif.rsp_rdata, 32'h00377600);
    check("r_err", 32'(bif.rsp_error), 32'h0);
    handshake("r");

    // Write with wr_busy high for 3 cycles
    base = wr_en_cnt;
    bif.wr_busy = 1'b1;
    issue(1'b1, 14'h1004, 4'h5, 32'h11223344);
    check("b_wr_en_c1", 32'(bif.wr_en), 32'h0);
    @(negedge clk);
    check("b_wr_en_c2", 32'(bif.wr_en), 32'h0);
    @(negedge clk);
    check("b_wr_en_c3", 32'(bif.wr_en), 32'h0);
    check("b_rsp_c3", 32'(bif.rsp_valid), 32'h0);
    @(negedge clk);
    bif.wr_busy = 1'b0;
    #1;
    check("b_wr_en_c4", 32'(bif.wr_en), 32'h1);
    check("b_rsp_c4", 32'(bif.rsp_valid), 32'h0);
    @(negedge clk);
    check("b_rsp_e4", 32'(bif.rsp_valid), 32'h1);
    check("b_err", 32'(bif.rsp_error), 32'h0);
    handshake("b");
    check("b_pulses", 32'(wr_en_cnt - base), 32'h1);

    // wr_busy stuck high: timeout after BUSY_TO cycles
    base = wr_en_cnt;
    bif.wr_busy = 1'b1;
    issue(1'b1, 14'h1008, 4'hF, 32'h55AA55AA);
    wait_rsp("t", 8);
    check("t_err", 32'(bif.rsp_error), 32'h1);
    check("t_rdata", bif.rsp_rdata, 32'h0);
    handshake("t");
    bif.wr_busy = 1'b0;
    check("t_pulses", 32'(wr_en_cnt - base), 32'h0);

    // ROM read, response stalled 5 cycles with a new command waiting
    issue(1'b0, {REGION_ROM, 12'h005}, 4'hF, 32'h0);
    wait_rsp("s", 2);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 14'h1010;
    bif.cmd_be    = 4'h3;
    bif.cmd_wdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      check("s_rsp_valid", 32'(bif.rsp_valid), 32'h1);
      check("s_rdata", bif.rsp_rdata, 32'hCAFEF00D);
      check("s_err", 32'(bif.rsp_error), 32'h0);
      check("s_cmd_ready", 32'(bif.cmd_ready), 32'h0);
      check("s_wr_en", 32'(bif.wr_en), 32'h0);
      @(negedge clk);
    end
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    check("s_rsp_done", 32'(bif.rsp_valid), 32'h0);
    check("s_cmd_ready_next", 32'(bif.cmd_ready), 32'h1);
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    check("s2_cmd_ready", 32'(bif.cmd_ready), 32'h0);
    check("s2_wr_en", 32'(bif.wr_en), 32'h1);
    check("s2_wr_addr", 32'(bif.wr_addr), 32'h1010);
    check("s2_wr_be", 32'(bif.wr_be), 32'h03);
    check("s2_wr_data", bif.wr_data, 32'h12345678);
    wait_rsp("s2", 1);
    handshake("s2");

    // Reset during READ_WAIT
    issue(1'b0, 14'h1002, 4'hF, 32'h0);
    check("x_rd_addr", 32'(bif.rd_addr), 32'h1002);
    sys_rst_n = 1'b0;
    #1;
    check("x_rsp_valid", 32'(bif.rsp_valid), 32'h0);
    check("x_rd_addr0", 32'(bif.rd_addr), 32'h0);
    check("x_rd_be0", 32'(bif.rd_be), 32'h0);
    check("x_wr_addr0", 32'(bif.wr_addr), 32'h0);
    check("x_wr_be0", 32'(bif.wr_be), 32'h0);
    check("x_wr_data0", bif.wr_data, 32'h0);
    check("x_wr_en0", 32'(bif.wr_en), 32'h0);
    check("x_cmd_ready", 32'(bif.cmd_ready), 32'h1);
    @(negedge clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("x_no_rsp", 32'(bif.rsp_valid), 32'h0);
      check("x_idle", 32'(bif.cmd_ready), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_mem_requester.md
PIO_MEM_REQUESTER -- requirements
Module: pio_mem_requester

Interface
REQ-001 SHALL have parameter TCQ, default 1, clock-to-output delay applied to all registered assignments.
REQ-002 SHALL have parameter RD_LATENCY, default 1, number of cycles the target needs from a stable rd_addr to a valid rd_data; legal 1..7.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 255, maximum consecutive cycles to wait on wr_busy; legal 1..255.
REQ-004 SHALL have clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have sys_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have cmd_valid, input, 1, command present.
REQ-007 SHALL have cmd_ready, output, 1, command accepted this cycle when high with cmd_valid.
REQ-008 SHALL have cmd_write, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have cmd_addr, input, 14, DWORD address; [13:12] selects region (01 = BAR0 registers, 11 = BIOS ROM).
REQ-010 SHALL have cmd_be, input, 4, byte enables; bit 0 = data[31:24] ... bit 3 = data[7:0].
REQ-011 SHALL have cmd_wdata, input, 32, write data.
REQ-012 SHALL have rsp_valid, output, 1, completion present.
REQ-013 SHALL have rsp_ready, input, 1, completion consumed when high with rsp_valid.
REQ-014 SHALL have rsp_rdata, output, 32, read data; 0 for writes and errors.
REQ-015 SHALL have rsp_error, output, 1, write abandoned on wr_busy timeout.
REQ-016 SHALL have rd_addr / rd_be, outputs, 14 / 4, target read port.
REQ-017 SHALL have rd_data, input, 32, target read data.
REQ-018 SHALL have wr_addr / wr_be / wr_data / wr_en, outputs, 14 / 8 / 32 / 1, target write port.
REQ-019 SHALL have wr_busy, input, 1, target cannot accept a write.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ_WAIT, RESP; cmd_ready = (state == IDLE).
REQ-021 SHALL, on acceptance at edge E0, register addr/be/wdata/write and go to WRITE if cmd_write, else READ_WAIT.
REQ-022 SHALL drive wr_en = (state == WRITE) & !wr_busy, combinationally; exactly one wr_en pulse per write command.
REQ-023 SHALL leave WRITE for RESP on the edge where wr_en is high, with rsp_error = 0 (no-busy latency: rsp_valid from E0+1).
REQ-024 SHALL count consecutive wr_busy cycles in WRITE; on reaching BUSY_TIMEOUT, go to RESP with rsp_error = 1 and no wr_en ever issued.
REQ-025 SHALL drive wr_be = {4'b0, be}; wr_addr, wr_data, rd_addr and rd_be hold their last values outside active states.
REQ-026 SHALL keep rd_addr/rd_be stable from E0 until capture, load a counter with RD_LATENCY at E0, and capture rd_data into rsp_rdata at edge E0+RD_LATENCY+1, entering RESP.
REQ-027 SHALL hold rsp_valid, rsp_rdata and rsp_error stable in RESP until rsp_ready; on handshake go to IDLE (cmd_ready high the next cycle, so at most one command is outstanding).
REQ-028 SHALL ignore cmd_* inputs outside IDLE; never assert wr_en in READ_WAIT, RESP or IDLE.

Reset
REQ-029 SHALL, on sys_rst_n low, asynchronously force state IDLE, counters 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, rd_addr 0, rd_be 0, wr_addr 0, wr_be 0, wr_data 0; wr_en drops in the same cycle.
REQ-030 SHALL discard any in-flight command on reset; no response is produced for it after release.

Structure
REQ-031 SHALL place the state enumeration, ADDR_W = 14, BE_W = 4 and region codes (BAR0 = 2'b01, ROM = 2'b11) in shared package pio_mem_pkg.
REQ-032 SHALL be a single module with no sub-module; FSM and counters inline.

Verification
REQ-033 Write 0x1000, be 0xF, data 0x0A0015C8, wr_busy 0 -> wr_en one cycle after E0 with wr_be 0x0F; rsp_valid at E0+1, rsp_error 0, rsp_rdata 0.
REQ-034 Read 0x1002 with RD_LATENCY = 1, target returning 0x00377600 -> rd_addr 0x1002 held two cycles; rsp_rdata 0x00377600 at E0+2.
REQ-035 Write with wr_busy high for 3 cycles -> exactly one wr_en, in cycle 4 after E0; rsp_valid at E0+4, rsp_error 0.
REQ-036 BUSY_TIMEOUT = 8, wr_busy stuck high -> no wr_en; rsp_valid at E0+8, rsp_error 1, rsp_rdata 0.
REQ-037 rsp_ready low 5 cycles with cmd_valid high -> rsp fields stable, cmd_ready 0 throughout; next command accepted the cycle after handshake.
REQ-038 sys_rst_n low for 1 cycle during READ_WAIT -> all outputs 0 immediately; no rsp_valid after release; cmd_ready 1.
